// File: rtl/intr_pkg.sv
// Shared constants, state encoding and arbitration helper for the 8085-style
// interrupt controller.
package intr_pkg;

  localparam logic [15:0] VEC_TRAP = 16'h0024;
  localparam logic [15:0] VEC_R75  = 16'h003C;
  localparam logic [15:0] VEC_R65  = 16'h0034;
  localparam logic [15:0] VEC_R55  = 16'h002C;

  // Source indices double as priority order: lower index wins.
  localparam int SRC_TRAP = 0;
  localparam int SRC_R75  = 1;
  localparam int SRC_R65  = 2;
  localparam int SRC_R55  = 3;
  localparam int SRC_INTR = 4;
  localparam int NUM_SRC  = 5;

  localparam int SIM_M55 = 0;
  localparam int SIM_M65 = 1;
  localparam int SIM_M75 = 2;
  localparam int SIM_MSE = 3;
  localparam int SIM_R75 = 4;
  localparam int SIM_SDE = 6;
  localparam int SIM_SOD = 7;

  localparam int RIM_M55 = 0;
  localparam int RIM_M65 = 1;
  localparam int RIM_M75 = 2;
  localparam int RIM_IE  = 3;
  localparam int RIM_I55 = 4;
  localparam int RIM_I65 = 5;
  localparam int RIM_I75 = 6;
  localparam int RIM_SID = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_PEND = 2'b10
  } intr_state_e;

  // One-hot winner: isolates the lowest set bit, i.e. the highest priority.
  function automatic logic [NUM_SRC-1:0] prio_sel(input logic [NUM_SRC-1:0] req);
    return req & (~req + 1'b1);
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Control-unit side of the interrupt controller: instruction strobes,
// sample/acknowledge handshake and the captured vector.
interface intr_ctrl_if #(
  parameter int ADDR_SIZE = 16
);
  import intr_pkg::*;

  // Handshake: irq_req acts as valid and holds irq_ext/irq_vect stable until a
  // one-cycle ack is seen while irq_req=1; ack with irq_req=0 is ignored.
  logic                 inst_ei;
  logic                 inst_di;
  logic                 inst_sim;
  logic [7:0]           sim_data;
  logic                 smpl;
  logic                 ack;
  logic                 irq_req;
  logic                 irq_ext;
  logic [ADDR_SIZE-1:0] irq_vect;
  logic                 inte;
  logic [7:0]           rim_data;
  intr_state_e          state_dbg;

  modport master (
    output inst_ei, inst_di, inst_sim, sim_data, smpl, ack,
    input  irq_req, irq_ext, irq_vect, inte, rim_data, state_dbg
  );

  modport slave (
    input  inst_ei, inst_di, inst_sim, sim_data, smpl, ack,
    output irq_req, irq_ext, irq_vect, inte, rim_data, state_dbg
  );

endinterface

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a one-cycle pulse on
// each rising edge of the synchronised level.
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_,
  input  logic rst_,
  input  logic pin,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   prev;

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], pin};
      prev <= sr[SYNC_STAGES-1];
    end
  end

  assign sync = sr[SYNC_STAGES-1];
  assign rise = sr[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// 8085-style interrupt controller: pin sync, TRAP/RST7.5 edge latches, SIM
// masks, INTE with EI delay, and capture/hold of the winning request.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_SIZE   = 16
) (
  input  logic              clk_,
  input  logic              rst_,
  input  logic              pin_trap,
  input  logic              pin_r75,
  input  logic              pin_r65,
  input  logic              pin_r55,
  input  logic              pin_intr,
  input  logic              pin_sid,
  output logic              pin_sod,
  intr_ctrl_if.slave        bus
);

  logic [5:0] pin_raw;
  logic [5:0] pin_synced;
  logic [5:0] pin_rise;
  logic [3:0] unused_rise;
  logic       unused_sim5;

  assign pin_raw = {pin_sid, pin_intr, pin_r55, pin_r65, pin_r75, pin_trap};

  for (genvar g = 0; g < 6; g++) begin : g_sync
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_ (clk_),
      .rst_ (rst_),
      .pin  (pin_raw[g]),
      .sync (pin_synced[g]),
      .rise (pin_rise[g])
    );
  end

  // Only TRAP and RST7.5 are edge sensitive.
  assign unused_rise = pin_rise[5:2];
  assign unused_sim5 = bus.sim_data[5];

  logic trap_sync, r75_sync, r65_sync, r55_sync, intr_sync, sid_sync;
  assign trap_sync = pin_synced[0];
  assign r75_sync  = pin_synced[1];
  assign r65_sync  = pin_synced[2];
  assign r55_sync  = pin_synced[3];
  assign intr_sync = pin_synced[4];
  assign sid_sync  = pin_synced[5];

  intr_state_e          state, state_nxt;
  logic                 trap_latch, r75_latch;
  logic                 m75, m65, m55;
  logic                 inte_q, ei_dly;
  logic                 inte_nxt, ei_nxt;
  logic                 irq_req_q, irq_ext_q;
  logic [ADDR_SIZE-1:0] irq_vect_q, win_vect;
  logic [NUM_SRC-1:0]   req, win, cap_src;
  logic                 cap_en, ack_take, sim_mask_wr, sim_r75_clr;

  assign sim_mask_wr = bus.inst_sim & bus.sim_data[SIM_MSE];
  assign sim_r75_clr = sim_mask_wr & bus.sim_data[SIM_R75];

  assign req[SRC_TRAP] = trap_latch & trap_sync;
  assign req[SRC_R75]  = r75_latch & ~m75 & inte_q;
  assign req[SRC_R65]  = r65_sync & ~m65 & inte_q;
  assign req[SRC_R55]  = r55_sync & ~m55 & inte_q;
  assign req[SRC_INTR] = intr_sync & inte_q;
  assign win           = prio_sel(req);

  always_comb begin
    win_vect = '0;
    if (win[SRC_TRAP])     win_vect = ADDR_SIZE'(VEC_TRAP);
    else if (win[SRC_R75]) win_vect = ADDR_SIZE'(VEC_R75);
    else if (win[SRC_R65]) win_vect = ADDR_SIZE'(VEC_R65);
    else if (win[SRC_R55]) win_vect = ADDR_SIZE'(VEC_R55);
  end

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    ack_take  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.smpl && (req != '0)) begin
          cap_en    = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (bus.ack) begin
          ack_take  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      irq_req_q  <= 1'b0;
      irq_ext_q  <= 1'b0;
      irq_vect_q <= '0;
      cap_src    <= '0;
    end else if (cap_en) begin
      irq_req_q  <= 1'b1;
      irq_ext_q  <= win[SRC_INTR];
      irq_vect_q <= win_vect;
      cap_src    <= win;
    end else if (ack_take) begin
      irq_req_q  <= 1'b0;
      irq_ext_q  <= 1'b0;
      cap_src    <= '0;
    end
  end

  // A fresh edge takes precedence over any clear in the same cycle.
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      trap_latch <= 1'b0;
      r75_latch  <= 1'b0;
    end else begin
      if (pin_rise[0])                           trap_latch <= 1'b1;
      else if (ack_take && cap_src[SRC_TRAP])    trap_latch <= 1'b0;
      if (pin_rise[1])                           r75_latch  <= 1'b1;
      else if ((ack_take && cap_src[SRC_R75]) || sim_r75_clr)
                                                 r75_latch  <= 1'b0;
    end
  end

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      m75     <= 1'b1;
      m65     <= 1'b1;
      m55     <= 1'b1;
      pin_sod <= 1'b0;
    end else if (bus.inst_sim) begin
      if (bus.sim_data[SIM_MSE]) begin
        m75 <= bus.sim_data[SIM_M75];
        m65 <= bus.sim_data[SIM_M65];
        m55 <= bus.sim_data[SIM_M55];
      end
      if (bus.sim_data[SIM_SDE]) pin_sod <= bus.sim_data[SIM_SOD];
    end
  end

  // Ordering: EI promotion at smpl, then ack clear, then EI arm, then DI.
  always_comb begin
    inte_nxt = inte_q;
    ei_nxt   = ei_dly;
    if (bus.smpl && ei_dly) begin
      inte_nxt = 1'b1;
      ei_nxt   = 1'b0;
    end
    if (ack_take) begin
      inte_nxt = 1'b0;
      ei_nxt   = 1'b0;
    end
    if (bus.inst_ei) ei_nxt = 1'b1;
    if (bus.inst_di) begin
      inte_nxt = 1'b0;
      ei_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      inte_q <= 1'b0;
      ei_dly <= 1'b0;
    end else begin
      inte_q <= inte_nxt;
      ei_dly <= ei_nxt;
    end
  end

  assign bus.irq_req   = irq_req_q;
  assign bus.irq_ext   = irq_ext_q;
  assign bus.irq_vect  = irq_vect_q;
  assign bus.inte      = inte_q;
  assign bus.state_dbg = state;
  assign bus.rim_data  = {sid_sync, r75_latch, r65_sync, r55_sync,
                          inte_q, m75, m65, m55};

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: expected captures are queued at each sample
// strobe and checked by a monitor when irq_req rises.
module tb_intr_ctrl;
  import intr_pkg::*;

  localparam int W = 17;

  logic clk_ = 1'b0;
  logic rst_ = 1'b1;
  logic pin_trap = 0, pin_r75 = 0, pin_r65 = 0, pin_r55 = 0, pin_intr = 0, pin_sid = 0;
  logic pin_sod;

  intr_ctrl_if #(.ADDR_SIZE(16)) bus ();

  intr_ctrl #(.SYNC_STAGES(2), .ADDR_SIZE(16)) dut (
    .clk_     (clk_),
    .rst_     (rst_),
    .pin_trap (pin_trap),
    .pin_r75  (pin_r75),
    .pin_r65  (pin_r65),
    .pin_r55  (pin_r55),
    .pin_intr (pin_intr),
    .pin_sid  (pin_sid),
    .pin_sod  (pin_sod),
    .bus      (bus)
  );

  always #5 clk_ = ~clk_;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new capture must match the head of the expected queue.
  initial begin : monitor
    logic         prev;
    logic [W-1:0] exp_v;
    prev = 1'b0;
    forever begin
      @(negedge clk_);
      if (rst_) prev = 1'b0;
      else begin
        if (bus.irq_req && !prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: got 0x%0h expected none", {bus.irq_ext, bus.irq_vect});
          end else begin
            exp_v = exp_q.pop_front();
            if ({bus.irq_ext, bus.irq_vect} !== exp_v) begin
              errors++;
              $display("FAIL capture: got 0x%0h expected 0x%0h", {bus.irq_ext, bus.irq_vect}, exp_v);
            end
          end
        end
        prev = bus.irq_req;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_);
    #1;
  endtask

  task automatic settle();
    step(4);
  endtask

  task automatic do_sim(input logic [7:0] d);
    bus.sim_data = d; bus.inst_sim = 1'b1; step(); bus.inst_sim = 1'b0;
  endtask

  task automatic do_ei();
    bus.inst_ei = 1'b1; step(); bus.inst_ei = 1'b0;
  endtask

  task automatic do_smpl();
    bus.smpl = 1'b1; step(); bus.smpl = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
  endtask

  task automatic expect_cap(input logic ext, input logic [15:0] vect);
    exp_q.push_back({ext, vect});
    do_smpl();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk_);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    bus.inst_ei = 0; bus.inst_di = 0; bus.inst_sim = 0; bus.sim_data = '0;
    bus.smpl = 0; bus.ack = 0;
    step(3);
    check("rst_irq_req", 32'(bus.irq_req), 32'd0);
    check("rst_irq_ext", 32'(bus.irq_ext), 32'd0);
    check("rst_irq_vect", 32'(bus.irq_vect), 32'd0);
    check("rst_rim", 32'(bus.rim_data), 32'h07);
    check("rst_sod", 32'(pin_sod), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    rst_ = 1'b0;
    step();

    // RST6.5 basic path with EI delay
    do_sim(8'h08);
    check("masks_clear_rim", 32'(bus.rim_data), 32'h00);
    do_ei();
    check("ei_delayed", 32'(bus.inte), 32'd0);
    do_smpl();
    check("ei_promoted", 32'(bus.inte), 32'd1);
    check("no_req_idle", 32'(bus.irq_req), 32'd0);
    pin_r65 = 1; settle();
    check("rim_r65", 32'(bus.rim_data), 32'h28);
    expect_cap(1'b0, 16'h0034);
    check("pend_state", 32'(bus.state_dbg), 32'(ST_PEND));
    do_ack();
    check("ack_req_clr", 32'(bus.irq_req), 32'd0);
    check("ack_inte_clr", 32'(bus.inte), 32'd0);
    check("vect_kept", 32'(bus.irq_vect), 32'h0034);
    pin_r65 = 0; settle();

    // RST7.5 one-cycle pulse is latched
    do_ei(); do_smpl();
    pin_r75 = 1; step(); pin_r75 = 0; settle();
    check("rim_r75_latched", 32'(bus.rim_data), 32'h48);
    expect_cap(1'b0, 16'h003C);
    do_smpl();
    check("pend_ignores_smpl", 32'(bus.irq_vect), 32'h003C);
    check("rim_r75_pend", 32'(bus.rim_data[6]), 32'd1);
    do_ack();
    check("rim_r75_acked", 32'(bus.rim_data), 32'h00);

    // TRAP ignores inte; edge consumed by ack
    pin_intr = 1; pin_trap = 1; settle();
    expect_cap(1'b0, 16'h0024);
    do_ack();
    do_smpl();
    check("trap_consumed", 32'(bus.irq_req), 32'd0);
    pin_trap = 0;

    // 6.5 beats 5.5 and INTR; EI delay after ack
    pin_r55 = 1; pin_r65 = 1; settle();
    do_ei(); do_smpl();
    check("ei_first_smpl", 32'(bus.irq_req), 32'd0);
    expect_cap(1'b0, 16'h0034);
    do_ack();
    do_ei(); do_smpl();
    check("ei_delay_again", 32'(bus.irq_req), 32'd0);
    expect_cap(1'b0, 16'h0034);
    do_ack();

    // Masks set: INTR wins with external vectoring
    do_sim(8'h0F);
    do_ei(); do_smpl();
    expect_cap(1'b1, 16'h0000);
    check("intr_ext", 32'(bus.irq_ext), 32'd1);
    bus.ack = 1'b1; bus.inst_ei = 1'b1; step(); bus.ack = 1'b0; bus.inst_ei = 1'b0;
    check("ack_ext_clr", 32'(bus.irq_ext), 32'd0);
    check("ack_ei_inte", 32'(bus.inte), 32'd0);
    do_smpl();
    check("ack_ei_no_cap", 32'(bus.irq_req), 32'd0);
    check("ack_ei_promote", 32'(bus.inte), 32'd1);
    bus.inst_di = 1'b1; bus.inst_ei = 1'b1; step(); bus.inst_di = 1'b0; bus.inst_ei = 1'b0;
    check("di_wins", 32'(bus.inte), 32'd0);
    do_smpl();
    check("di_clears_dly", 32'(bus.inte), 32'd0);
    pin_intr = 0; pin_r55 = 0; pin_r65 = 0;
    do_sim(8'h08); settle();

    // SIM R7.5 clear, SOD, and set-wins coincidence
    pin_r75 = 1; step(); pin_r75 = 0; settle();
    check("r75_set", 32'(bus.rim_data[6]), 32'd1);
    do_sim(8'hD8);
    check("sim_r75_clr", 32'(bus.rim_data[6]), 32'd0);
    check("sim_sod", 32'(pin_sod), 32'd1);
    check("sim_masks", 32'(bus.rim_data[2:0]), 32'd0);
    pin_r75 = 1; step(2);
    do_sim(8'hD8);
    check("set_wins", 32'(bus.rim_data[6]), 32'd1);
    pin_r75 = 0; settle();
    do_sim(8'h40);
    check("sod_low", 32'(pin_sod), 32'd0);
    check("no_mse_keep", 32'(bus.rim_data[6]), 32'd1);

    // Async reset while pending
    do_sim(8'hC0);
    do_ei(); do_smpl();
    expect_cap(1'b0, 16'h003C);
    rst_ = 1'b1;
    #1;
    check("rst_pend_req", 32'(bus.irq_req), 32'd0);
    check("rst_pend_inte", 32'(bus.inte), 32'd0);
    check("rst_pend_rim", 32'(bus.rim_data), 32'h07);
    check("rst_pend_sod", 32'(pin_sod), 32'd0);
    check("rst_pend_vect", 32'(bus.irq_vect), 32'd0);
    step(2);
    rst_ = 1'b0;
    step(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- 8085-style interrupt controller that arbitrates TRAP, RST7.5, RST6.5, RST5.5 and INTR for the core control unit.
- Synchronises the pins, latches the edge-triggered sources and applies the SIM masks and the INTE flag.
- At each instruction-boundary sample strobe from control, captures the highest-priority request and holds it until control acknowledges the vectoring cycle.
- Also provides the RIM status byte and the SOD serial output latch.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchroniser (minimum 2).
- ADDR_SIZE, 16, width of the vector address output.

Ports:
- clk_  in  1  core clock; all state changes on rising edge.
- rst_  in  1  reset, asynchronous, active-high.
- pin_trap  in  1  TRAP pin, async.
- pin_r75  in  1  RST7.5 pin, async, rising-edge sensitive.
- pin_r65  in  1  RST6.5 pin, async, level.
- pin_r55  in  1  RST5.5 pin, async, level.
- pin_intr  in  1  INTR pin, async, level.
- pin_sid  in  1  serial input data, async.
- inst_ei  in  1  one-cycle strobe, EI executed.
- inst_di  in  1  one-cycle strobe, DI executed.
- inst_sim  in  1  one-cycle strobe, SIM executed.
- sim_data  in  8  accumulator value for SIM.
- smpl  in  1  one-cycle strobe: instruction boundary (last state of last machine cycle, or every cycle in halt).
- ack  in  1  one-cycle strobe: control has taken the captured interrupt.
- irq_req  out  1  captured interrupt pending, vector valid.
- irq_ext  out  1  captured source is INTR; control must run an INTA cycle.
- irq_vect  out  ADDR_SIZE  restart address; 0 when irq_ext.
- inte  out  1  interrupt-enable flag.
- rim_data  out  8  RIM byte.
- pin_sod  out  1  serial output data latch.

Behaviour:
- Reset values: irq_req=0, irq_ext=0, irq_vect=0, inte=0, ei_dly=0, masks M7.5/M6.5/M5.5=1, trap/r75 latches=0, pin_sod=0, synchronisers=0, FSM=IDLE.
- Synchroniser latency: a pin high before edge k is seen synced after edge k+SYNC_STAGES-1.
  - Edge detect compares the synced value with the previous synced value.
  - The trap/r75 latch sets on the following edge (k+SYNC_STAGES).
- TRAP request = trap_latch AND synced TRAP level. It is not maskable and ignores inte.
- RST7.5 request = r75_latch AND NOT M7.5. r75_latch clears on ack of RST7.5, or on SIM with bit3 (MSE)=1 and bit4 (R7.5)=1.
- RST6.5 request = synced level AND NOT M6.5. RST5.5 request = synced level AND NOT M5.5. Neither is latched.
- Maskable requests (7.5, 6.5, 5.5, INTR) are qualified by inte.
- Priority, highest first, with vectors:
  - TRAP 0x0024
  - RST7.5 0x003C
  - RST6.5 0x0034
  - RST5.5 0x002C
  - INTR: irq_ext=1, vector 0
- SIM:
  - If bit3=1, masks <= bits2:0.
  - If bit6 (SDE)=1, pin_sod <= bit7.
  - A SIM in PEND does not alter the captured request.
- rim_data = {synced SID, r75_latch, synced R6.5, synced R5.5, inte, M7.5, M6.5, M5.5}. Combinational from registers.
- INTE:
  - inst_ei sets ei_dly. At the next smpl, the sample is evaluated with the old inte, then inte<=1 and ei_dly<=0. This gives the one-instruction EI delay.
  - inst_di clears inte and ei_dly immediately. DI wins if it arrives in the same cycle as EI.
- FSM:
  - IDLE: on smpl with any qualified request, capture the winner into irq_vect/irq_ext, set irq_req=1, go to PEND. Otherwise stay.
  - PEND: outputs held stable; smpl is ignored. On ack: clear the source latch (TRAP or R7.5 only), inte<=0, ei_dly<=0, irq_req<=0, irq_ext<=0, go to IDLE. irq_vect keeps its last value.
  - ack in IDLE: ignored.
- Simultaneous events:
  - A new rising edge in the same cycle as a latch clear (ack or SIM R7.5): set wins.
  - ack and inst_ei in the same cycle: ack clears inte, then ei_dly <= 1 from EI.
- Reset mid-PEND: request dropped and all state returns to reset values. Control is reset by the same rst_.

Decomposition:
- Shared package intr_pkg:
  - vector constants VEC_TRAP, VEC_R75, VEC_R65, VEC_R55
  - source-index constants
  - SIM bit indices (M55=0..SOD=7)
  - RIM bit indices
  - FSM state encodings (IDLE, PEND; one-hot style as the control unit)
- Sub-module pin_sync: SYNC_STAGES synchroniser plus rising-edge pulse output. Instantiated six times (five interrupt pins and SID; the edge output is unused for the level pins).

Test Plan:
- After reset, inst_sim sim_data=0x08, inst_ei, one smpl, then pin_r65=1 and next smpl -> irq_req=1, irq_vect=0x0034, irq_ext=0. ack -> irq_req=0, inte=0.
- pin_r75 pulsed high 1 cycle (masks cleared, inte=1), then pin_r75 low before smpl -> irq_vect=0x003C at smpl. rim_data bit6=1 before ack, 0 after ack.
- inte=0 with pin_intr=1 and pin_trap rising and held -> smpl gives irq_vect=0x0024. After ack, TRAP held high and smpl -> no new request (edge consumed).
- pin_r55, pin_r65, pin_intr all high, masks 000, inte=1 -> vector 0x0034. After ack and EI, the next two smpl -> first ignored (EI delay), second gives 0x0034 again.
- inst_sim sim_data=0xD8 -> pin_sod=1, masks=000, r75_latch cleared. Same cycle as a synced R7.5 edge -> latch remains 1.
- rst_ asserted during PEND -> irq_req=0, inte=0, rim_data=0x07 immediately (async), with SID/R6.5/R5.5 pins low.
